// File: rtl/ysyx_24100006_icache_refill_pkg.sv
// Shared encodings for the ICache line-refill AXI4 read master.
package ysyx_24100006_icache_refill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    RESP = 2'd3
  } refill_state_e;

  localparam logic [2:0] AXI_SIZE_4B   = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_24100006_perf_cnt.sv
// 32-bit enable counter, wraps modulo 2^32, synchronous active-high reset.
module ysyx_24100006_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (reset)   count <= '0;
    else if (en) count <= count + 32'd1;
  end

endmodule

// File: rtl/ysyx_24100006_icache_refill.sv
// ICache line refill: one AXI4 INCR read burst per miss, line returned whole with an error flag.
// Optional perf counters are built only when ICACHE_REFILL_PERF_EN is defined.
module ysyx_24100006_icache_refill
  import ysyx_24100006_icache_refill_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [31:0]             resp_addr,
  output logic [LINE_WORDS*32-1:0] resp_data,
  output logic                    resp_err,
  output logic [31:0]             axi_araddr,
  output logic [7:0]              axi_arlen,
  output logic [2:0]              axi_arsize,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [31:0]             axi_rdata,
  input  logic [1:0]              axi_rresp,
  input  logic                    axi_rlast,
  input  logic                    axi_rvalid,
  output logic                    axi_rready,
  output logic [31:0]             perf_refills,
  output logic [31:0]             perf_cycles
);

  localparam int LINE_BYTES = LINE_WORDS * 4;
  localparam int CNT_W      = $clog2(LINE_WORDS);

  refill_state_e                  state;
  logic [CNT_W-1:0]               cnt;
  logic                           err;
  logic [LINE_WORDS-1:0][31:0]    line;
  logic                           last_word, final_beat, beat_err;
  logic [31:0]                    base;

  assign req_ready  = (state == IDLE);
  assign axi_arlen  = 8'(LINE_WORDS - 1);
  assign axi_arsize = AXI_SIZE_4B;
  assign resp_data  = line;
  assign base       = req_addr & ~32'(LINE_BYTES - 1);

  // A beat ends the burst on the counted last word or on rlast; any disagreement is an error.
  assign last_word  = (cnt == CNT_W'(LINE_WORDS - 1));
  assign final_beat = last_word || axi_rlast;
  assign beat_err   = (axi_rresp != AXI_RESP_OKAY) || (final_beat && (axi_rlast != last_word));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      axi_araddr  <= '0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_addr   <= '0;
      line        <= '0;
      cnt         <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          axi_araddr  <= base;
          resp_addr   <= base;
          axi_arvalid <= 1'b1;
          err         <= 1'b0;
          cnt         <= '0;
          state       <= AR;
        end
        AR: if (axi_arready) begin
          axi_arvalid <= 1'b0;
          axi_rready  <= 1'b1;
          state       <= R;
        end
        R: if (axi_rvalid) begin
          line[cnt] <= axi_rdata;
          cnt       <= cnt + 1'b1;
          err       <= err | beat_err;
          if (final_beat) begin
            axi_rready <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= err | beat_err;
            state      <= RESP;
          end
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_REFILL_PERF_EN
  logic [1:0]       perf_en;
  logic [1:0][31:0] perf_cnt;

  assign perf_en = {state != IDLE, (state == RESP) && resp_ready};

  for (genvar g = 0; g < 2; g++) begin : g_perf
    ysyx_24100006_perf_cnt u_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (perf_en[g]),
      .count (perf_cnt[g])
    );
  end

  assign perf_refills = perf_cnt[0];
  assign perf_cycles  = perf_cnt[1];
`else
  assign perf_refills = '0;
  assign perf_cycles  = '0;
`endif

endmodule

// File: doc/ysyx_24100006_icache_refill.md
Name: ysyx_24100006_icache_refill

Overview:
AXI4 read-only burst master that refills one instruction-cache line from the memory slave.
- Accepts a line-miss request from the ICache and issues one INCR burst of LINE_WORDS 32-bit beats.
- Assembles the beats into a line buffer and returns the whole line plus an error flag.
- Sits directly upstream of the memory slave's AR/R channels; this block never drives the write channels.

Parameters:
- LINE_WORDS, 4, words per cache line; power of 2, range 2..16.
- LINE_BYTES, LINE_WORDS*4, derived localparam; not overridable.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  ICache miss request valid.
- req_ready  out  1  request accepted when high with req_valid; combinational, equal to (state==IDLE).
- req_addr  in  32  miss address; any byte alignment.
- resp_valid  out  1  refilled line valid.
- resp_ready  in  1  ICache accepts line.
- resp_addr  out  32  line-aligned base address of the returned line.
- resp_data  out  LINE_WORDS*32  line; word i occupies bits [32i+31:32i].
- resp_err  out  1  refill error flag.
- axi_araddr  out  32  burst start address.
- axi_arlen  out  8  constant LINE_WORDS-1.
- axi_arsize  out  3  constant 3'b010.
- axi_arvalid  out  1  AR valid.
- axi_arready  in  1  AR ready.
- axi_rdata  in  32  read data.
- axi_rresp  in  2  read response.
- axi_rlast  in  1  last beat.
- axi_rvalid  in  1  R valid.
- axi_rready  out  1  R ready.
- perf_refills  out  32  refill counter; optional feature.
- perf_cycles  out  32  refill cycle counter; optional feature.

Behaviour:
- Reset values: axi_arvalid=0, axi_rready=0, axi_araddr=0, resp_valid=0, resp_err=0, resp_addr=0, resp_data=0, beat counter=0, state=IDLE.
- Reset mid-burst abandons the burst immediately. Beats still in flight from the slave are not consumed by this block; the system resets both ends together.
- Handshakes: a transfer occurs at a posedge where valid and ready are both high. Once asserted, a valid stays high and its payload stays stable until its handshake.

State machine:
- IDLE
  - req_ready=1.
  - On req handshake: latch base = req_addr & ~(LINE_BYTES-1); axi_araddr<=base; axi_arvalid<=1; clear err and counter; go AR.
- AR
  - Hold axi_arvalid and axi_araddr until axi_arready is sampled high. This tolerates a slave that raises arready one or more cycles after arvalid.
  - On handshake: axi_arvalid<=0; axi_rready<=1; go R.
- R
  - axi_rready stays 1.
  - Each beat: word[cnt]<=axi_rdata; err |= (axi_rresp!=2'b00); cnt<=cnt+1.
  - Beat is final when cnt==LINE_WORDS-1 or axi_rlast==1.
    - Final beat: err |= (axi_rlast != (cnt==LINE_WORDS-1)).
    - Early rlast leaves unreceived words holding stale data, with err=1.
  - Final beat: axi_rready<=0; resp_valid<=1; resp_err<=err including this beat; go RESP.
- RESP
  - Hold resp_* stable until resp_ready.
  - On handshake: resp_valid<=0; go IDLE.
  - A new request is never accepted in the same cycle as the resp handshake.

Latency and boundaries:
- Minimum latency from req handshake to resp_valid = 3 + LINE_WORDS cycles against a zero-wait slave: arready arrives 1 cycle late, first rvalid 1 cycle after AR handshake.
- Counter width is clog2(LINE_WORDS) bits; it never wraps within a burst because the final beat forces exit.
- req_addr near 0xFFFF_FFFF is aligned down; there is no address wrap inside a burst.

Optional Feature:
- Macro ICACHE_REFILL_PERF_EN.
- Defined:
  - perf_refills increments by 1 on each resp handshake.
  - perf_cycles increments every cycle state!=IDLE.
  - Both counters are 32-bit, wrap modulo 2^32, and reset to 0.
- Undefined:
  - Both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, AR=1, R=2, RESP=3);
  - AXI_SIZE_4B=3'b010;
  - AXI_RESP_OKAY=2'b00.
- One sub-module is natural: ysyx_24100006_perf_cnt, a 32-bit enable counter instantiated twice under ICACHE_REFILL_PERF_EN.
- The line buffer and FSM stay in this module.

Test Plan:
1. Aligned refill: req_addr=0x8000_0010, memory words 0x11,0x22,0x33,0x44 -> araddr=0x8000_0010, arlen=3, arsize=2, resp_data={0x44,0x33,0x22,0x11}, resp_err=0, resp_valid 7 cycles after req handshake.
2. Unaligned request: req_addr=0x8000_002E -> araddr=0x8000_0020, resp_addr=0x8000_0020.
3. Backpressure: arready delayed 5 cycles, rvalid gapped every other cycle, resp_ready held low 4 cycles -> arvalid/araddr and resp_* stable throughout, correct data, req_ready=0 until the cycle after resp handshake.
4. Error cases:
   - rresp=2'b10 on beat 2 -> resp_err=1, remaining beats still consumed.
   - Early rlast on beat 1 -> resp after 2 beats, resp_err=1.
5. Reset asserted for 1 cycle while in R after 2 beats -> next cycle all outputs at reset values and req_ready=1; a following refill of 0x8000_0000 completes correctly.
6. With ICACHE_REFILL_PERF_EN: 3 back-to-back refills -> perf_refills=3 and perf_cycles=3*(3+LINE_WORDS+1) against a zero-wait slave; without the macro both counters read 0.
